enemy_sprite_engine: RTL and testbench

Parametrised renderer for the enemy-plane layer of the game. It takes a snapshot of up to N_ENEMY enemy coordinates and a visibility mask from the enemy control FSM. It then streams one VGA pixel per clock: first it erases every sprite drawn in the previous frame, then it draws every visible sprite at its new position. It sits between the enemy control block and the VGA adapter. Compared with the fixed 10-plane, single-pixel datapath, it adds a configurable plane count, multi-pixel sprites, automatic erase of the previous frame, edge clipping and a selectable render mode.

---
 rtl/enemy_sprite_engine.sv | 183 ++++++++++++++++++
 tb/tb_enemy_sprite_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sprite_engine.sv
// Enemy-plane sprite renderer: erases the previous frame's sprites, then draws the new ones, one pixel per clock.
// Latency: first pixel one cycle after LOAD; no backpressure, start is ignored while busy.
module enemy_sprite_engine #(
  parameter int N_ENEMY = 10,
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [N_ENEMY*XW-1:0] x_in,
  input  logic [N_ENEMY*YW-1:0] y_in,
  input  logic [N_ENEMY-1:0]    vis_in,
  output logic [XW-1:0]         x_out,
  output logic [YW-1:0]         y_out,
  output logic [2:0]            colour_out,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);

  localparam int SW  = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t state, state_n;
  logic [SW-1:0]  slot, slot_n;
  logic [DXW-1:0] dx, dx_n;
  logic [DYW-1:0] dy, dy_n;
  logic [1:0]     mode_r;

  logic [N_ENEMY*XW-1:0] old_x, new_x;
  logic [N_ENEMY*YW-1:0] old_y, new_y;
  logic [N_ENEMY-1:0]    old_vis, new_vis;

  logic          cur_vis, last_dx, last_px, last_slot;
  logic [XW-1:0] src_x;
  logic [YW-1:0] src_y;
  logic          src_vis;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [2:0]    colour_d;
  logic          plot_d, busy_d, done_d;

  // Visibility of the slot currently on the output, in the snapshot of its phase
  assign cur_vis   = (state == S_ERASE) ? old_vis[slot] : new_vis[slot];
  assign last_dx   = (dx == DXW'(SPR_W - 1));
  assign last_px   = last_dx && (dy == DYW'(SPR_H - 1));
  assign last_slot = (slot == SW'(N_ENEMY - 1));

  always_comb begin
    state_n = state;
    slot_n  = slot;
    dx_n    = dx;
    dy_n    = dy;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          slot_n  = '0;
          dx_n    = '0;
          dy_n    = '0;
        end
      end
      S_LOAD: begin
        state_n = (mode_r == 2'b01) ? S_DRAW : S_ERASE;
        slot_n  = '0;
        dx_n    = '0;
        dy_n    = '0;
      end
      S_ERASE, S_DRAW: begin
        if (cur_vis && !last_px) begin
          if (last_dx) begin
            dx_n = '0;
            dy_n = dy + 1'b1;
          end else begin
            dx_n = dx + 1'b1;
          end
        end else begin
          dx_n = '0;
          dy_n = '0;
          if (last_slot) begin
            slot_n  = '0;
            state_n = (state == S_ERASE && mode_r != 2'b10) ? S_DRAW : S_DONE;
          end else begin
            slot_n = slot + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are derived from the next position so they register alongside it;
  // a DRAW straight out of LOAD reads the inputs being captured at that same edge.
  always_comb begin
    src_x   = old_x[slot_n*XW +: XW];
    src_y   = old_y[slot_n*YW +: YW];
    src_vis = old_vis[slot_n];
    if (state_n == S_DRAW) begin
      if (state == S_LOAD) begin
        src_x   = x_in[slot_n*XW +: XW];
        src_y   = y_in[slot_n*YW +: YW];
        src_vis = vis_in[slot_n];
      end else begin
        src_x   = new_x[slot_n*XW +: XW];
        src_y   = new_y[slot_n*YW +: YW];
        src_vis = new_vis[slot_n];
      end
    end
    sum_x    = {1'b0, src_x} + (XW+1)'(dx_n);
    sum_y    = {1'b0, src_y} + (YW+1)'(dy_n);
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    if (state_n == S_ERASE || state_n == S_DRAW) begin
      x_d      = sum_x[XW-1:0];
      y_d      = sum_y[YW-1:0];
      colour_d = (state_n == S_ERASE) ? BG_COLOUR : FG_COLOUR;
      plot_d   = src_vis && !sum_x[XW] && !sum_y[YW];
    end
    busy_d = (state_n != S_IDLE);
    done_d = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      slot       <= '0;
      dx         <= '0;
      dy         <= '0;
      mode_r     <= 2'b00;
      old_x      <= '0;
      old_y      <= '0;
      old_vis    <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_vis    <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      dx    <= dx_n;
      dy    <= dy_n;
      if (state == S_IDLE && start)
        mode_r <= (mode == 2'b11) ? 2'b00 : mode;
      if (state == S_LOAD) begin
        new_x   <= x_in;
        new_y   <= y_in;
        new_vis <= vis_in;
      end
      // After an erase-only frame nothing remains on screen to erase next time
      if (state == S_DONE) begin
        old_x   <= new_x;
        old_y   <= new_y;
        old_vis <= (mode_r == 2'b10) ? '0 : new_vis;
      end
      x_out      <= x_d;
      y_out      <= y_d;
      colour_out <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_enemy_sprite_engine.sv
// Directed bench for enemy_sprite_engine with default parameters; cycle c is sampled #1 after the c-th edge following the start edge.
module tb_enemy_sprite_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [79:0] x_in = '0;
  logic [79:0] y_in = '0;
  logic [9:0]  vis_in = '0;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic       cp [0:63];
  logic [7:0] cx [0:63];
  logic [7:0] cy [0:63];
  logic [2:0] cc [0:63];
  logic       cb [0:63];
  logic       cd [0:63];

  enemy_sprite_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .vis_in(vis_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_slot0(input logic [7:0] x, input logic [7:0] y, input logic v);
    x_in = '0;
    y_in = '0;
    vis_in = '0;
    x_in[7:0] = x;
    y_in[7:0] = y;
    vis_in[0] = v;
  endtask

  task automatic store(input int c);
    cp[c] = plot; cx[c] = x_out; cy[c] = y_out;
    cc[c] = colour_out; cb[c] = busy; cd[c] = done;
  endtask

  // Starts a frame and records ncyc cycles; start / reset are raised for one cycle after sample pulse_at / rst_at.
  task automatic run_frame(input logic [1:0] m, input int ncyc, input int pulse_at, input int rst_at);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    store(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      store(c);
      start = (c == pulse_at);
      reset = (c == rst_at);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int first_done(input int ncyc);
    for (int c = 1; c <= ncyc; c++)
      if (cd[c]) return c;
    return -1;
  endfunction

  function automatic int count_plots(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++)
      if (cp[c]) n++;
    return n;
  endfunction

  task automatic test_reset;
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({x_out, y_out, colour_out, plot, busy, done} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got x=%0d y=%0d col=%0b plot=%0b busy=%0b done=%0b, want all 0",
               x_out, y_out, colour_out, plot, busy, done);
    end
    reset = 1'b0;
    set_slot0(8'd0, 8'd0, 1'b0);
    run_frame(2'b00, 24, 0, 0);
    vectors++;
    if (cb[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_at_start_edge: got %0b, want 1", cb[0]);
    end
    n = count_plots(1, 24);
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL empty_frame_plots: got %0d, want 0", n);
    end
    n = first_done(24);
    vectors++;
    if (n !== 21) begin
      miscompares++;
      $display("FAIL empty_frame_done_cycle: got %0d, want 21", n);
    end
    vectors++;
    if (cd[22] !== 1'b0 || cb[22] !== 1'b0 || cb[21] !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_frame_tail: got done22=%0b busy22=%0b busy21=%0b, want 0 0 1", cd[22], cb[22], cb[21]);
    end
  endtask

  task automatic test_first_frame;
    int n;
    set_slot0(8'd10, 8'd20, 1'b1);
    run_frame(2'b00, 38, 0, 0);
    n = count_plots(1, 10);
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL first_erase_plots: got %0d, want 0", n);
    end
    for (int p = 0; p < 16; p++) begin
      vectors++;
      if (cp[11+p] !== 1'b1 || cx[11+p] !== 8'(10 + p % 4) || cy[11+p] !== 8'(20 + p / 4) || cc[11+p] !== 3'b100) begin
        miscompares++;
        $display("FAIL first_draw_px%0d: got plot=%0b (%0d,%0d) col=%0b, want 1 (%0d,%0d) col=100",
                 p, cp[11+p], cx[11+p], cy[11+p], cc[11+p], 10 + p % 4, 20 + p / 4);
      end
    end
    n = count_plots(27, 38);
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL first_draw_skip_plots: got %0d, want 0", n);
    end
    n = first_done(38);
    vectors++;
    if (n !== 36) begin
      miscompares++;
      $display("FAIL first_done_cycle: got %0d, want 36", n);
    end
  endtask

  task automatic test_second_frame;
    int n;
    set_slot0(8'd11, 8'd20, 1'b1);
    run_frame(2'b00, 53, 0, 0);
    for (int p = 0; p < 16; p++) begin
      vectors++;
      if (cp[1+p] !== 1'b1 || cx[1+p] !== 8'(10 + p % 4) || cy[1+p] !== 8'(20 + p / 4) || cc[1+p] !== 3'b000) begin
        miscompares++;
        $display("FAIL second_erase_px%0d: got plot=%0b (%0d,%0d) col=%0b, want 1 (%0d,%0d) col=000",
                 p, cp[1+p], cx[1+p], cy[1+p], cc[1+p], 10 + p % 4, 20 + p / 4);
      end
      vectors++;
      if (cp[26+p] !== 1'b1 || cx[26+p] !== 8'(11 + p % 4) || cy[26+p] !== 8'(20 + p / 4) || cc[26+p] !== 3'b100) begin
        miscompares++;
        $display("FAIL second_draw_px%0d: got plot=%0b (%0d,%0d) col=%0b, want 1 (%0d,%0d) col=100",
                 p, cp[26+p], cx[26+p], cy[26+p], cc[26+p], 11 + p % 4, 20 + p / 4);
      end
    end
    n = count_plots(17, 25) + count_plots(42, 53);
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL second_skip_plots: got %0d, want 0", n);
    end
    n = first_done(53);
    vectors++;
    if (n !== 51) begin
      miscompares++;
      $display("FAIL second_done_cycle: got %0d, want 51", n);
    end
  endtask

  task automatic test_clipping;
    int n;
    logic exp_plot;
    set_slot0(8'd254, 8'd253, 1'b1);
    run_frame(2'b01, 28, 0, 0);
    for (int p = 0; p < 16; p++) begin
      exp_plot = (254 + p % 4 <= 255) && (253 + p / 4 <= 255);
      vectors++;
      if (cp[1+p] !== exp_plot || (exp_plot && (cx[1+p] !== 8'(254 + p % 4) || cy[1+p] !== 8'(253 + p / 4)))) begin
        miscompares++;
        $display("FAIL clip_px%0d: got plot=%0b (%0d,%0d), want plot=%0b", p, cp[1+p], cx[1+p], cy[1+p], exp_plot);
      end
    end
    n = count_plots(1, 28);
    vectors++;
    if (n !== 6) begin
      miscompares++;
      $display("FAIL clip_plot_count: got %0d, want 6", n);
    end
    n = first_done(28);
    vectors++;
    if (n !== 26) begin
      miscompares++;
      $display("FAIL clip_done_cycle: got %0d, want 26", n);
    end
  endtask

  task automatic test_ignored_start;
    int n;
    set_slot0(8'd40, 8'd40, 1'b1);
    run_frame(2'b10, 34, 5, 0);
    n = 0;
    for (int c = 1; c <= 34; c++)
      if (cd[c]) n++;
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL ignored_start_done_count: got %0d, want 1", n);
    end
    n = first_done(34);
    vectors++;
    if (n !== 26) begin
      miscompares++;
      $display("FAIL ignored_start_done_cycle: got %0d, want 26", n);
    end
    n = count_plots(1, 34);
    vectors++;
    if (n !== 6 || cc[1] !== 3'b000 || cx[1] !== 8'd254 || cy[1] !== 8'd253) begin
      miscompares++;
      $display("FAIL erase_only_plots: got %0d first=(%0d,%0d) col=%0b, want 6 (254,253) col=000", n, cx[1], cy[1], cc[1]);
    end
    vectors++;
    if (cb[27] !== 1'b0 || cb[34] !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_start_requeued: got busy27=%0b busy34=%0b, want 0 0", cb[27], cb[34]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    set_slot0(8'd10, 8'd20, 1'b1);
    run_frame(2'b11, 40, 0, 18);
    vectors++;
    if (cp[18] !== 1'b1 || cc[18] !== 3'b100) begin
      miscompares++;
      $display("FAIL mode3_draw_before_reset: got plot=%0b col=%0b, want 1 100", cp[18], cc[18]);
    end
    vectors++;
    if ({cx[19], cy[19], cc[19], cp[19], cb[19], cd[19]} !== 22'd0) begin
      miscompares++;
      $display("FAIL midframe_reset_outputs: got x=%0d y=%0d col=%0b plot=%0b busy=%0b done=%0b, want all 0",
               cx[19], cy[19], cc[19], cp[19], cb[19], cd[19]);
    end
    n = 0;
    for (int c = 19; c <= 40; c++)
      if (cd[c] || cb[c] || cp[c]) n++;
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL midframe_reset_abandon: got %0d active cycles, want 0", n);
    end
    run_frame(2'b00, 38, 0, 0);
    n = count_plots(1, 10);
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL post_reset_erase_plots: got %0d, want 0", n);
    end
    n = count_plots(11, 26);
    vectors++;
    if (n !== 16 || cx[11] !== 8'd10 || cy[26] !== 8'd23) begin
      miscompares++;
      $display("FAIL post_reset_draw: got %0d plots x11=%0d y26=%0d, want 16 10 23", n, cx[11], cy[26]);
    end
    n = first_done(38);
    vectors++;
    if (n !== 36) begin
      miscompares++;
      $display("FAIL post_reset_done_cycle: got %0d, want 36", n);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    set_slot0(8'd0, 8'd0, 1'b0);
    run_frame(2'b01, 27, 12, 0);
    vectors++;
    if (cd[11] !== 1'b1 || cb[12] !== 1'b0 || cb[13] !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back_restart: got done11=%0b busy12=%0b busy13=%0b, want 1 0 1", cd[11], cb[12], cb[13]);
    end
    n = 0;
    for (int c = 12; c <= 27; c++)
      if (cd[c]) begin
        n = c;
        break;
      end
    vectors++;
    if (n !== 24) begin
      miscompares++;
      $display("FAIL back_to_back_done_cycle: got %0d, want 24", n);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_clipping();
    test_ignored_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
